// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared types and constants for the two-digit seven-segment scanner.
//   seg7_t       : one digit's segment code, bit0 = segment a
//   SEG_OFF      : all segments dark (active-high sense)
//   scan_state_e : scan sequence SHOW0 -> BLANK0 -> SHOW1 -> BLANK1
//   max2         : elaboration-time helper for sizing the cycle counter
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF = 7'b0000000;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } scan_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan -- time-multiplexed driver for a two-digit seven-segment display.
//
// Frames arrive over a valid/ready handshake into a one-entry pending
// register and are promoted to the displayed register only at frame
// boundaries, so a digit pair is never shown torn.
//
// Parameters
//   DIV   : cycles each digit is lit (>= 1)
//   BLANK : all-off cycles after each digit (>= 1)
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   s_valid    : upstream frame valid
//   s_ready    : pending slot empty, frame can be accepted
//   s_data     : [0] = ones digit, [1] = tens digit segment codes
//   seg        : segment drive for the selected digit
//   an         : digit select, an[0] = ones, an[1] = tens
//   frame_tick : one-cycle pulse on the last cycle of each scan frame
// Build option
//   SEG7_SCAN_ACTIVE_LOW_EN : when defined, seg and an are inverted at the
//   ports for common-anode displays; internal timing is unchanged.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [1:0][6:0] s_data,
  output logic [6:0]      seg,
  output logic [1:0]      an,
  output logic            frame_tick
);

  localparam int CNT_W = $clog2(max2(DIV, BLANK) + 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seg7_t [1:0]      pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  seg7_t [1:0]      act_q, act_d;

  logic             last_cycle;
  logic             tick;
  seg7_t            seg_int;
  logic [1:0]       an_int;

  assign s_ready = !pend_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;

    if (state_q == SHOW0 || state_q == SHOW1) begin
      last_cycle = (cnt_q == DIV_LAST);
    end else begin
      last_cycle = (cnt_q == BLANK_LAST);
    end

    if (last_cycle) begin
      cnt_d = '0;
      unique case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        BLANK1:  state_d = SHOW0;
        default: state_d = SHOW0;
      endcase
    end

    tick = (state_q == BLANK1) && last_cycle;

    // Promotion and capture are mutually exclusive: a full pend holds
    // s_ready low, so a frame_tick handshake only ever lands in an empty
    // pend and waits for the following boundary.
    if (tick && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (s_valid && s_ready) begin
      pend_d       = s_data;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SHOW0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      act_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      act_q        <= act_d;
    end
  end

  always_comb begin
    seg_int = SEG_OFF;
    an_int  = 2'b00;
    unique case (state_q)
      SHOW0: begin
        seg_int = act_q[0];
        an_int  = 2'b01;
      end
      SHOW1: begin
        seg_int = act_q[1];
        an_int  = 2'b10;
      end
      default: begin
        seg_int = SEG_OFF;
        an_int  = 2'b00;
      end
    endcase
  end

  assign frame_tick = tick;

`ifdef SEG7_SCAN_ACTIVE_LOW_EN
  assign seg = ~seg_int;
  assign an  = ~an_int;
`else
  assign seg = seg_int;
  assign an  = an_int;
`endif

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan -- scoreboard bench for seg7_scan (default DIV=4, BLANK=1).
// Stimulus pushes expected display frames (keyed by frame number) and
// expected s_ready samples (keyed by frame/position); a monitor walks a
// frame-position model every cycle and compares the DUT outputs.
module tb_seg7_scan;

  logic            clk;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [1:0][6:0] s_data;
  logic [6:0]      seg;
  logic [1:0]      an;
  logic            frame_tick;

  seg7_scan dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    logic [13:0] val;
  } exp_t;

  typedef struct {
    int   frame;
    int   pos;
    logic rdy;
  } rdy_t;

  exp_t exp_q[$];
  rdy_t rdy_q[$];

  int n_checks;
  int n_fails;
  int timeouts;
  int timeouts_seen;

  // Frame position model: 10-cycle frame, restarts with rst.
  int pos;
  int frame_num;
  always @(posedge clk) begin
    if (rst) begin
      pos       <= 0;
      frame_num <= 0;
    end else if (pos == 9) begin
      pos       <= 0;
      frame_num <= frame_num + 1;
    end else begin
      pos <= pos + 1;
    end
  end

  // Monitor / scoreboard
  logic [13:0] cur;
  logic [6:0]  e_seg;
  logic [1:0]  e_an;
  logic        e_tick;
  initial begin
    n_checks      = 0;
    n_fails       = 0;
    timeouts_seen = 0;
    cur           = '0;
  end

  always @(negedge clk) begin
    if (timeouts != timeouts_seen) begin
      n_checks++;
      n_fails++;
      $display("FAIL handshake_timeout: got %0d timeouts, required 0", timeouts);
      timeouts_seen = timeouts;
    end
    if (rst) begin
      cur = '0;
    end else begin
      if (pos == 0 && exp_q.size() > 0 && exp_q[0].frame == frame_num) begin
        cur = exp_q[0].val;
        void'(exp_q.pop_front());
      end
      e_seg  = 7'b0000000;
      e_an   = 2'b00;
      e_tick = (pos == 9);
      if (pos <= 3) begin
        e_seg = cur[6:0];
        e_an  = 2'b01;
      end else if (pos >= 5 && pos <= 8) begin
        e_seg = cur[13:7];
        e_an  = 2'b10;
      end
`ifdef SEG7_SCAN_ACTIVE_LOW_EN
      e_seg = ~e_seg;
      e_an  = ~e_an;
`endif
      n_checks++;
      if (an !== e_an) begin
        n_fails++;
        $display("FAIL an f%0d p%0d: got %b, required %b", frame_num, pos, an, e_an);
      end
      n_checks++;
      if (seg !== e_seg) begin
        n_fails++;
        $display("FAIL seg f%0d p%0d: got %b, required %b", frame_num, pos, seg, e_seg);
      end
      n_checks++;
      if (frame_tick !== e_tick) begin
        n_fails++;
        $display("FAIL frame_tick f%0d p%0d: got %b, required %b", frame_num, pos, frame_tick, e_tick);
      end
      if (rdy_q.size() > 0 && rdy_q[0].frame == frame_num && rdy_q[0].pos == pos) begin
        n_checks++;
        if (s_ready !== rdy_q[0].rdy) begin
          n_fails++;
          $display("FAIL s_ready f%0d p%0d: got %b, required %b", frame_num, pos, s_ready, rdy_q[0].rdy);
        end
        void'(rdy_q.pop_front());
      end
    end
  end

  task automatic wait_pos(input int f, input int p);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_num == f && pos == p) return;
    end
    timeouts++;
  endtask

  // Offer one frame; returns #1 after the accepting edge with s_valid low.
  task automatic send(input logic [13:0] v);
    s_valid = 1'b1;
    s_data  = v;
    for (int i = 0; i < 50; i++) begin
      if (s_ready) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        $display("accepted frame %b at frame %0d", v, frame_num);
        return;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    timeouts++;
  endtask

  task automatic push_rdy(input int f, input int p, input logic r);
    rdy_t e;
    e.frame = f;
    e.pos   = p;
    e.rdy   = r;
    rdy_q.push_back(e);
  endtask

  task automatic push_exp(input int f, input logic [13:0] v);
    exp_t e;
    e.frame = f;
    e.val   = v;
    exp_q.push_back(e);
  endtask

  localparam logic [13:0] V1 = {7'b0000110, 7'b0111111};
  localparam logic [13:0] VA = {7'b1011011, 7'b1001111};
  localparam logic [13:0] VB = {7'b1100110, 7'b1101101};
  localparam logic [13:0] VC = {7'b1111101, 7'b0000111};
  localparam logic [13:0] VD = {7'b1111111, 7'b1101111};
  localparam logic [13:0] VE = {7'b1110111, 7'b1111100};

  initial begin
    timeouts = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;

    // Reset held 3 cycles; first cycle after: an=01, seg=0, s_ready=1.
    push_rdy(0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single frame accepted at cycle 2, shown from frame 1.
    push_rdy(0, 3, 1'b0);
    push_rdy(1, 0, 1'b1);
    wait_pos(0, 2);
    send(V1);
    push_exp(1, V1);

    // Back-to-back A, B: B waits for the boundary where A is promoted.
    push_rdy(2, 2, 1'b0);
    push_rdy(2, 9, 1'b0);
    push_rdy(3, 0, 1'b1);
    push_rdy(3, 1, 1'b0);
    wait_pos(2, 1);
    send(VA);
    push_exp(3, VA);
    send(VB);
    push_exp(4, VB);

    // Handshake in the frame_tick cycle: shown in the frame after next.
    push_rdy(6, 0, 1'b0);
    push_rdy(7, 0, 1'b1);
    wait_pos(5, 9);
    send(VC);
    push_exp(7, VC);

    // Mid-frame reset during SHOW1 with pend full: D is discarded.
    wait_pos(8, 1);
    send(VD);
    wait_pos(8, 6);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    push_rdy(0, 0, 1'b1);
    #1 rst = 1'b0;

    // Scanning restarts blank; new frame E then held for several frames.
    wait_pos(0, 3);
    send(VE);
    push_exp(1, VE);
    wait_pos(3, 9);
    @(posedge clk);
    #1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIV, default 4, number of cycles each digit is lit (legal DIV >= 1).
REQ-002 SHALL have parameter BLANK, default 1, number of all-off cycles after each digit (legal BLANK >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  upstream frame valid.
REQ-006 SHALL have port s_ready  output  1  block can accept a frame.
REQ-007 SHALL have port s_data  input  [1:0][6:0]  segment codes; [0] = ones digit, [1] = tens digit, bit0 = segment a.
REQ-008 SHALL have port seg  output  7  segment drive for the currently selected digit.
REQ-009 SHALL have port an  output  2  digit select; an[0] = ones, an[1] = tens.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse on the last cycle of each scan frame.

Function
REQ-011 SHALL hold a one-entry pending register (pend, pend_valid) and an active display register (act).
REQ-012 SHALL drive s_ready = !pend_valid combinationally from the register.
REQ-013 SHALL, on s_valid && s_ready, capture s_data into pend and set pend_valid; s_data is ignored otherwise.
REQ-014 SHALL sequence states SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
REQ-015 SHALL keep each SHOW state for exactly DIV cycles and each BLANK state for exactly BLANK cycles; frame period = 2*(DIV+BLANK) cycles (10 with defaults).
REQ-016 SHALL use a cycle counter of width $clog2(max(DIV,BLANK)+1) that restarts at 0 on every state change.
REQ-017 SHALL decode outputs combinationally from registered state: SHOW0 gives an=01, seg=act[0]; SHOW1 gives an=10, seg=act[1]; BLANK0/BLANK1 give an=00, seg=0.
REQ-018 SHALL assert frame_tick only during the last cycle of BLANK1.
REQ-019 SHALL, at the clock edge ending a frame_tick cycle with pend_valid=1, copy pend to act and clear pend_valid; the new frame is visible from the first following SHOW0 cycle.
REQ-020 SHALL update act only at frame boundaries, so no frame is shown torn across digits.
REQ-021 SHALL, when a handshake occurs in the frame_tick cycle with pend empty, load pend only; act is updated at the next boundary.
REQ-022 SHALL keep showing act indefinitely when no new frame arrives.
REQ-023 SHALL hold s_ready low while pend is full, giving at most one frame in flight plus one displayed.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set state=SHOW0, counter=0, pend_valid=0, pend=0, act=0.
REQ-025 SHALL, in the cycle after reset, show an=01, seg=0000000, s_ready=1, frame_tick=0.
REQ-026 SHALL, on reset mid-frame, discard any pending frame and restart scanning at SHOW0.

Configuration
REQ-027 SHALL invert seg and an at the ports when SEG7_SCAN_ACTIVE_LOW_EN is defined, for common-anode displays; the blank state then drives seg=1111111 and an=11.
REQ-028 SHALL drive seg and an active-high when SEG7_SCAN_ACTIVE_LOW_EN is undefined; internal registers and timing are identical in both builds.

Structure
REQ-029 SHALL take the scan state enum (SHOW0, BLANK0, SHOW1, BLANK1), the seg7_t = logic [6:0] typedef and the SEG_OFF constant from shared package seg7_pkg.
REQ-030 SHALL be a single module with no sub-modules; the counter and FSM live in seg7_scan.

Verification
REQ-031 SHALL cover reset: rst held 3 cycles, then released -> an=01, seg=0, s_ready=1, frame_tick first high on cycle 10.
REQ-032 SHALL cover a single frame: s_data={0000110, 0111111} accepted at cycle 2 -> next SHOW0 shows seg=0111111/an=01 for 4 cycles, BLANK 1 cycle, then seg=0000110/an=10 for 4 cycles.
REQ-033 SHALL cover backpressure: frames A then B offered back-to-back -> A accepted, s_ready low until the boundary where A goes to act, B accepted the next cycle, B displayed one frame after A.
REQ-034 SHALL cover a boundary handshake: frame accepted exactly in the frame_tick cycle -> displayed starting in the frame after next, not the immediately following SHOW0.
REQ-035 SHALL cover mid-frame reset: rst asserted during SHOW1 with pend full -> pend discarded, act=0, scan restarts at SHOW0.
REQ-036 SHALL cover the active-low build: with SEG7_SCAN_ACTIVE_LOW_EN defined, repeating REQ-032 gives seg=1000000/an=10 during SHOW0 and seg=1111111/an=11 during blank.
